// File: rtl/j1_boot_ram.sv
// Dual-port program/data RAM for the j1 core with a streaming boot loader.
// The loader fills the RAM after reset and then releases the core after a fixed delay.
//
// state | meaning
// LOAD  | accepting loader beats into RAM, core held in reset
// HOLD  | loading finished, counting RELEASE_DELAY cycles before release
// RUN   | core released, port B owned by the core
module j1_boot_ram #(
    parameter int    LOG2ABITS     = 11,
    parameter int    DWIDTH        = 16,
    parameter string MEM_INIT_FILE = "",
    parameter bit    BOOT_ENABLE   = 1'b1,
    parameter int    RELEASE_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 resetq,
    input  logic [LOG2ABITS-1:0] code_addr,
    output logic [DWIDTH-1:0]    insn,
    input  logic [LOG2ABITS-1:0] mem_addr,
    input  logic                 mem_wr,
    input  logic [DWIDTH-1:0]    dout,
    output logic [DWIDTH-1:0]    din,
    input  logic                 ld_valid,
    input  logic [DWIDTH-1:0]    ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic [LOG2ABITS:0]   ld_count,
    output logic                 cpu_reset,
    output logic                 boot_done
);
    localparam int DEPTH = 2 ** LOG2ABITS;
    localparam logic [7:0] DLY_TC = 8'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    state_t                 state;
    logic [7:0]             dly_cnt;
    logic [DWIDTH-1:0]      mem [DEPTH];
    logic                   ld_acc;
    logic [LOG2ABITS-1:0]   ld_addr;
    logic                   last_beat;
    logic                   run_wr;
    logic                   mem_we;
    logic [LOG2ABITS-1:0]   wr_addr;
    logic [DWIDTH-1:0]      wr_data;

    assign ld_ready  = (state == LOAD) && resetq;
    assign ld_acc    = ld_valid && ld_ready;
    assign ld_addr   = ld_count[LOG2ABITS-1:0];
    assign last_beat = ld_last || (ld_addr == '1);
    assign run_wr    = (state == RUN) && mem_wr;

    // Loader and core never write in the same state, so one shared write port suffices.
    always_comb begin
        mem_we  = 1'b0;
        wr_addr = mem_addr;
        wr_data = dout;
        if (ld_acc) begin
            mem_we  = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (run_wr) begin
            mem_we  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= wr_data;
    end

    // Reads sample the array before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            insn <= '0;
            din  <= '0;
        end else begin
            insn <= mem[code_addr];
            if (state == RUN && !mem_wr) din <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            if (BOOT_ENABLE) state <= LOAD;
            else             state <= HOLD;
            ld_count  <= '0;
            dly_cnt   <= '0;
            cpu_reset <= 1'b1;
            boot_done <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_acc) begin
                        ld_count <= ld_count + (LOG2ABITS+1)'(1);
                        if (last_beat) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (dly_cnt == DLY_TC) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                        boot_done <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
                RUN: begin
                    cpu_reset <= 1'b0;
                    boot_done <= 1'b1;
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule
